// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the 16550-style UART host sequencer:
//   register addresses, LSR bit positions, the sequencer state enum and
//   a helper that picks the effective baud divisor.
package uart_pkg;

    // Register addresses, DLAB-dependent aliases share one address.
    localparam logic [2:0] RBR_THR_DLL = 3'd0;
    localparam logic [2:0] IER_DLM     = 3'd1;
    localparam logic [2:0] FCR         = 3'd2;
    localparam logic [2:0] LCR         = 3'd3;
    localparam logic [2:0] LSR         = 3'd5;

    // LSR bit indices.
    localparam int DR   = 0;
    localparam int THRE = 5;

    // LCR value that opens the divisor latch.
    localparam logic [7:0] LCR_DLAB = 8'h80;

    typedef enum logic [3:0] {
        UNCFG,
        W_LCR_DL,
        W_DLM,
        W_DLL,
        W_LCR,
        W_FCR,
        IDLE,
        RD_LSR,
        RD_RBR,
        WR_THR
    } state_e;

    // A zero divisor would stop the baud generator, so fall back to a default.
    function automatic logic [15:0] eff_div(input logic [15:0] div,
                                            input logic [15:0] dflt);
        return (div == 16'd0) ? dflt : div;
    endfunction

endpackage

// File: rtl/uart_poll_timer.sv
// uart_poll_timer
//   Idle-cycle counter that paces autonomous LSR polls.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     en_i       : count this cycle
//     clr_i      : return to zero (wins over en_i)
//     tc_o       : high while enabled and the count equals TERM-1
module uart_poll_timer #(
    parameter int unsigned TERM = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else if (clr_i) begin
            cnt_q <= 16'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign tc_o = en_i && (cnt_q == 16'(TERM - 1));

endmodule

// File: rtl/uart_host_seq.sv
// uart_host_seq
//   Programs a 16550-style UART (divisor, LCR, FCR) on request, then
//   polls LSR to move received bytes out and transmit bytes in.
//   Ports:
//     clk, rst_n                 : clock, asynchronous active-low reset
//     cfg_start/div/lcr/fcr      : programming request and values
//     cfg_done                   : configured and servicing traffic
//     tx_valid/tx_data/tx_ready  : transmit byte handshake
//     rx_valid/rx_data/rx_err    : received byte strobe, data, LSR[4:1]
//     wr_o/rd_o/addr_o/wdata_o   : UART register bus (one access per cycle)
//     rdata_i                    : read data, valid in the rd_o cycle
//   All outputs are registered; the strobe for a state is computed on
//   the transition into that state.
module uart_host_seq
    import uart_pkg::*;
#(
    parameter int unsigned POLL_CYCLES = 16,
    parameter logic [15:0] DIV_RESET   = 16'h0108
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_start,
    input  logic [15:0] cfg_div,
    input  logic [7:0]  cfg_lcr,
    input  logic [7:0]  cfg_fcr,
    output logic        cfg_done,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [3:0]  rx_err,
    output logic        wr_o,
    output logic        rd_o,
    output logic [2:0]  addr_o,
    output logic [7:0]  wdata_o,
    input  logic [7:0]  rdata_i
);

    state_e      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [7:0]  lcr_q, lcr_d;
    logic [7:0]  fcr_q, fcr_d;
    logic [3:0]  lsr_err_q, lsr_err_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic [2:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        tx_ready_q, tx_ready_d;
    logic        cfg_done_q, cfg_done_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [3:0]  rx_err_q, rx_err_d;

    logic        poll_tc;
    logic        poll_clr;
    logic [15:0] div_eff;

    assign div_eff = eff_div(div_q, DIV_RESET);

    uart_poll_timer #(
        .TERM (POLL_CYCLES)
    ) u_poll (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == IDLE),
        .clr_i (poll_clr),
        .tc_o  (poll_tc)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        lcr_d      = lcr_q;
        fcr_d      = fcr_q;
        lsr_err_d  = lsr_err_q;
        rx_data_d  = rx_data_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = 1'b0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        addr_d     = 3'd0;
        wdata_d    = 8'd0;
        tx_ready_d = 1'b0;

        unique case (state_q)
            UNCFG, IDLE: begin
                if (cfg_start) begin
                    div_d   = cfg_div;
                    lcr_d   = cfg_lcr & 8'h7F;
                    fcr_d   = cfg_fcr;
                    state_d = W_LCR_DL;
                    wr_d    = 1'b1;
                    addr_d  = LCR;
                    wdata_d = LCR_DLAB;
                end else if ((state_q == IDLE) && (tx_valid || poll_tc)) begin
                    state_d = RD_LSR;
                    rd_d    = 1'b1;
                    addr_d  = LSR;
                end
            end
            W_LCR_DL: begin
                state_d = W_DLM;
                wr_d    = 1'b1;
                addr_d  = IER_DLM;
                wdata_d = div_eff[15:8];
            end
            W_DLM: begin
                state_d = W_DLL;
                wr_d    = 1'b1;
                addr_d  = RBR_THR_DLL;
                wdata_d = div_eff[7:0];
            end
            W_DLL: begin
                state_d = W_LCR;
                wr_d    = 1'b1;
                addr_d  = LCR;
                wdata_d = lcr_q;
            end
            W_LCR: begin
                state_d = W_FCR;
                wr_d    = 1'b1;
                addr_d  = FCR;
                wdata_d = fcr_q;
            end
            W_FCR: begin
                state_d = IDLE;
            end
            RD_LSR: begin
                lsr_err_d = rdata_i[4:1];
                // Receive wins so the RX FIFO cannot overrun while TX waits.
                if (rdata_i[DR]) begin
                    state_d = RD_RBR;
                    rd_d    = 1'b1;
                    addr_d  = RBR_THR_DLL;
                end else if (tx_valid && rdata_i[THRE]) begin
                    state_d    = WR_THR;
                    wr_d       = 1'b1;
                    addr_d     = RBR_THR_DLL;
                    wdata_d    = tx_data;
                    tx_ready_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RD_RBR: begin
                rx_valid_d = 1'b1;
                rx_data_d  = rdata_i;
                rx_err_d   = lsr_err_q;
                state_d    = IDLE;
            end
            WR_THR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = UNCFG;
            end
        endcase

        cfg_done_d = (state_d == IDLE) || (state_d == RD_LSR) ||
                     (state_d == RD_RBR) || (state_d == WR_THR);
    end

    // The counter restarts whenever IDLE is left, whatever the reason.
    assign poll_clr = (state_q == IDLE) && (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UNCFG;
            div_q      <= 16'd0;
            lcr_q      <= 8'd0;
            fcr_q      <= 8'd0;
            lsr_err_q  <= 4'd0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            addr_q     <= 3'd0;
            wdata_q    <= 8'd0;
            tx_ready_q <= 1'b0;
            cfg_done_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            rx_err_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            lcr_q      <= lcr_d;
            fcr_q      <= fcr_d;
            lsr_err_q  <= lsr_err_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tx_ready_q <= tx_ready_d;
            cfg_done_q <= cfg_done_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign wr_o     = wr_q;
    assign rd_o     = rd_q;
    assign addr_o   = addr_q;
    assign wdata_o  = wdata_q;
    assign tx_ready = tx_ready_q;
    assign cfg_done = cfg_done_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_uart_host_seq.sv
// tb_uart_host_seq
//   Directed plus randomized bench for uart_host_seq. A behavioural UART
//   register model answers reads from lsr_val/rbr_val; expected bus
//   traffic is derived from the programming and polling rules.
module tb_uart_host_seq;

    localparam int POLL = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start;
    logic [15:0] cfg_div;
    logic [7:0]  cfg_lcr;
    logic [7:0]  cfg_fcr;
    logic        cfg_done;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [3:0]  rx_err;
    logic        wr_o;
    logic        rd_o;
    logic [2:0]  addr_o;
    logic [7:0]  wdata_o;
    logic [7:0]  rdata_i;

    logic [7:0]  lsr_val;
    logic [7:0]  rbr_val;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // UART register model: LSR and RBR reads return the current stimulus values.
    assign rdata_i = !rd_o             ? 8'h00   :
                     (addr_o == 3'd5)  ? lsr_val :
                     (addr_o == 3'd0)  ? rbr_val : 8'h00;

    uart_host_seq #(
        .POLL_CYCLES (POLL),
        .DIV_RESET   (16'h0108)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_div   (cfg_div),
        .cfg_lcr   (cfg_lcr),
        .cfg_fcr   (cfg_fcr),
        .cfg_done  (cfg_done),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .wr_o      (wr_o),
        .rd_o      (rd_o),
        .addr_o    (addr_o),
        .wdata_o   (wdata_o),
        .rdata_i   (rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_bus(input string tag, input logic ew, input logic er,
                           input logic [2:0] ea, input logic [7:0] ed);
        chk(tag, {19'd0, wr_o, rd_o, addr_o, wdata_o}, {19'd0, ew, er, ea, ed});
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Bus protocol invariants, every cycle out of reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("one_strobe", {31'd0, wr_o & rd_o}, 32'd0);
            if (!wr_o && !rd_o)
                chk("quiet_bus", {21'd0, addr_o, wdata_o}, 32'd0);
            if (tx_ready)
                chk("ready_has_write", {31'd0, wr_o}, 32'd1);
        end
    end

    task automatic wait_idle(input string tag);
        bit got = 0;
        for (int i = 0; i < 60; i++) begin
            if (cfg_done && !wr_o && !rd_o && !rx_valid) begin
                got = 1;
                break;
            end
            cyc();
        end
        chk({tag, "_idle_timeout"}, {31'd0, got}, 32'd1);
    endtask

    task automatic wait_strobe(input string tag, input bit want_wr, input int budget);
        bit got = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (want_wr ? wr_o : rd_o) begin
                got = 1;
                break;
            end
        end
        chk({tag, "_timeout"}, {31'd0, got}, 32'd1);
    endtask

    // Run a programming sequence; poke re-pulses cfg_start mid-sequence.
    task automatic do_config(input string tag, input logic [15:0] div,
                             input logic [7:0] lcr, input logic [7:0] fcr, input bit poke);
        logic [2:0]  ea [5];
        logic [7:0]  ed [5];
        logic [15:0] d;
        d  = (div == 16'd0) ? 16'h0108 : div;
        ea = '{3'd3, 3'd1, 3'd0, 3'd3, 3'd2};
        ed = '{8'h80, d[15:8], d[7:0], {1'b0, lcr[6:0]}, fcr};
        cfg_div   = div;
        cfg_lcr   = lcr;
        cfg_fcr   = fcr;
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        cfg_div   = ~div;
        cfg_lcr   = ~lcr;
        cfg_fcr   = ~fcr;
        for (int i = 0; i < 5; i++) begin
            exp_bus($sformatf("%s_w%0d", tag, i), 1'b1, 1'b0, ea[i], ed[i]);
            chk($sformatf("%s_busy%0d", tag, i), {31'd0, cfg_done}, 32'd0);
            cfg_start = poke && (i == 1);
            cyc();
        end
        cfg_start = 1'b0;
        exp_bus({tag, "_end"}, 1'b0, 1'b0, 3'd0, 8'd0);
        chk({tag, "_done"}, {31'd0, cfg_done}, 32'd1);
        $display("config %s div=%h lcr=%h fcr=%h", tag, div, lcr, fcr);
    endtask

    task automatic do_tx(input string tag, input logic [7:0] data, input logic [7:0] lsr);
        wait_idle(tag);
        lsr_val  = lsr;
        tx_valid = 1'b1;
        tx_data  = data;
        cyc();
        exp_bus({tag, "_lsr"}, 1'b0, 1'b1, 3'd5, 8'd0);
        cyc();
        exp_bus({tag, "_thr"}, 1'b1, 1'b0, 3'd0, data);
        chk({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b0;
        lsr_val  = 8'h00;
        cyc();
        chk({tag, "_ready_low"}, {31'd0, tx_ready}, 32'd0);
        $display("tx %s data=%h lsr=%h", tag, data, lsr);
    endtask

    task automatic do_rx(input string tag, input logic [7:0] data, input logic [7:0] lsr);
        int gap;
        logic [3:0] err;
        err = 4'((lsr >> 1) & 8'h0F);
        wait_idle(tag);
        lsr_val = lsr;
        rbr_val = data;
        wait_strobe({tag, "_poll"}, 1'b0, POLL + 4);
        exp_bus({tag, "_lsr"}, 1'b0, 1'b1, 3'd5, 8'd0);
        cyc();
        exp_bus({tag, "_rbr"}, 1'b0, 1'b1, 3'd0, 8'd0);
        lsr_val = 8'h00;
        cyc();
        chk({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
        chk({tag, "_data"}, {24'd0, rx_data}, {24'd0, data});
        chk({tag, "_err"}, {28'd0, rx_err}, {28'd0, err});
        cyc();
        chk({tag, "_valid_low"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_hold"}, {20'd0, rx_err, rx_data}, {20'd0, err, data});
        // Poll spacing: the strobe cycle is the first of POLL idle cycles.
        gap = 1;
        while (!rd_o && gap < 3 * POLL) begin
            cyc();
            gap++;
        end
        chk({tag, "_gap"}, gap, POLL);
        $display("rx %s data=%h lsr=%h gap=%0d", tag, data, lsr, gap);
    endtask

    initial begin
        int n_rd;
        int n_wr;
        logic [7:0] b;
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        cfg_div   = 16'd0;
        cfg_lcr   = 8'd0;
        cfg_fcr   = 8'd0;
        tx_valid  = 1'b0;
        tx_data   = 8'd0;
        lsr_val   = 8'd0;
        rbr_val   = 8'd0;

        // Reset state
        repeat (3) cyc();
        exp_bus("rst_bus", 1'b0, 1'b0, 3'd0, 8'd0);
        chk("rst_flags", {29'd0, cfg_done, tx_ready, rx_valid}, 32'd0);
        chk("rst_rx", {20'd0, rx_err, rx_data}, 32'd0);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("uncfg_done", {31'd0, cfg_done}, 32'd0);
        $display("reset released");

        // Directed configuration, with an ignored mid-sequence cfg_start
        do_config("cfg_dir", 16'h0108, 8'h83, 8'h07, 1'b1);
        do_config("cfg_zero", 16'h0000, 8'hFF, 8'hC1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            wait_idle("cfg_rnd");
            do_config($sformatf("cfg_rnd%0d", k), 16'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end

        // Transmit
        do_tx("tx_dir", 8'hA5, 8'h60);
        for (int k = 0; k < 4; k++)
            do_tx($sformatf("tx_rnd%0d", k), 8'($urandom), 8'h20 | (8'($urandom) & 8'hDE));

        // Transmit blocked on THRE, then released
        wait_idle("txb");
        b = 8'($urandom);
        lsr_val  = 8'h00;
        tx_valid = 1'b1;
        tx_data  = b;
        n_rd = 0;
        n_wr = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (rd_o && addr_o == 3'd5) n_rd++;
            if (wr_o) n_wr++;
        end
        chk("txb_no_write", n_wr, 0);
        chk("txb_reads", n_rd, 6);
        lsr_val = 8'h20;
        wait_strobe("txb_release", 1'b1, 6);
        exp_bus("txb_thr", 1'b1, 1'b0, 3'd0, b);
        chk("txb_ready", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b0;
        lsr_val  = 8'h00;
        $display("tx blocked data=%h reads=%0d", b, n_rd);

        // Transmit abandoned before acceptance
        wait_idle("txa");
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        repeat (7) cyc();
        tx_valid = 1'b0;
        lsr_val  = 8'h20;
        n_wr = 0;
        n_rd = 0;
        for (int i = 0; i < 2 * POLL + 4; i++) begin
            cyc();
            if (wr_o) n_wr++;
            if (rd_o) n_rd++;
        end
        chk("txa_no_write", n_wr, 0);
        chk("txa_polls", {31'd0, n_rd > 0}, 32'd1);
        lsr_val = 8'h00;
        $display("tx abandoned writes=%0d polls=%0d", n_wr, n_rd);

        // Receive
        do_rx("rx_dir", 8'h3C, 8'h03);
        for (int k = 0; k < 3; k++)
            do_rx($sformatf("rx_rnd%0d", k), 8'($urandom), 8'h01 | (8'($urandom) & 8'h3E));

        // Collision: RBR read precedes THR write
        wait_idle("col");
        b = 8'($urandom);
        lsr_val  = 8'h21;
        rbr_val  = 8'hC3;
        tx_valid = 1'b1;
        tx_data  = b;
        cyc();
        exp_bus("col_lsr1", 1'b0, 1'b1, 3'd5, 8'd0);
        cyc();
        exp_bus("col_rbr", 1'b0, 1'b1, 3'd0, 8'd0);
        lsr_val = 8'h20;
        cyc();
        chk("col_rx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'hC3});
        exp_bus("col_gap", 1'b0, 1'b0, 3'd0, 8'd0);
        cyc();
        exp_bus("col_lsr2", 1'b0, 1'b1, 3'd5, 8'd0);
        cyc();
        exp_bus("col_thr", 1'b1, 1'b0, 3'd0, b);
        chk("col_ready", {31'd0, tx_ready}, 32'd1);
        tx_valid = 1'b0;
        lsr_val  = 8'h00;
        $display("collision rx=%h tx=%h", 8'hC3, b);

        // Reset in the middle of programming
        wait_idle("rst");
        cfg_div   = 16'h1234;
        cfg_lcr   = 8'h1B;
        cfg_fcr   = 8'h01;
        cfg_start = 1'b1;
        cyc();
        cfg_start = 1'b0;
        cyc();
        exp_bus("rst_wdlm", 1'b1, 1'b0, 3'd1, 8'h12);
        #2 rst_n = 1'b0;
        #1;
        exp_bus("rst_async_bus", 1'b0, 1'b0, 3'd0, 8'd0);
        chk("rst_async_flags", {29'd0, cfg_done, tx_ready, rx_valid}, 32'd0);
        chk("rst_async_rx", {20'd0, rx_err, rx_data}, 32'd0);
        cyc();
        rst_n    = 1'b1;
        tx_valid = 1'b1;
        lsr_val  = 8'h21;
        n_wr = 0;
        n_rd = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            if (wr_o) n_wr++;
            if (rd_o) n_rd++;
            if (cfg_done) n_rd++;
        end
        chk("rst_quiet_wr", n_wr, 0);
        chk("rst_quiet_rd", n_rd, 0);
        tx_valid = 1'b0;
        lsr_val  = 8'h00;
        $display("mid-sequence reset strobes=%0d", n_wr + n_rd);
        do_config("cfg_after_rst", 16'($urandom), 8'($urandom), 8'($urandom), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_host_seq.md
UART_HOST_SEQ -- requirements
Module: uart_host_seq

Interface
REQ-001 The block SHALL have parameter POLL_CYCLES, default 16: idle cycles between autonomous LSR polls, legal range 1..65535.
REQ-002 The block SHALL have parameter DIV_RESET, default 16'h0108: divisor used when cfg_div is 0.
REQ-003 The block SHALL have the following ports, one clock and one reset, with reset asynchronous and active-low:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  pulse that starts the programming sequence.
- cfg_div  in  16  baud divisor (DLM:DLL).
- cfg_lcr  in  8  line control; bit7 ignored.
- cfg_fcr  in  8  FIFO control value.
- cfg_done  out  1  high while configured and idle-capable.
- tx_valid  in  1  byte offered for transmit.
- tx_data  in  8  transmit byte, held while tx_valid=1.
- tx_ready  out  1  one-cycle accept strobe.
- rx_valid  out  1  one-cycle received-byte strobe.
- rx_data  out  8  received byte.
- rx_err  out  4  LSR[4:1] (BI,FE,PE,OE) captured with the byte.
- wr_o  out  1  register write strobe.
- rd_o  out  1  register read strobe.
- addr_o  out  3  register address.
- wdata_o  out  8  write data.
- rdata_i  in  8  read data, valid combinationally in the rd_o cycle.

Function
REQ-004 The block SHALL assert at most one of wr_o/rd_o per cycle, each for exactly one cycle per access; addr_o/wdata_o SHALL be 0 when neither is asserted.
REQ-005 The FSM SHALL have the states UNCFG, W_LCR_DL, W_DLM, W_DLL, W_LCR, W_FCR, IDLE, RD_LSR, RD_RBR and WR_THR.
REQ-006 On cfg_start in UNCFG or IDLE, the block SHALL issue one write per cycle: (3, 8'h80), (1, div[15:8]), (0, div[7:0]), (3, {1'b0, cfg_lcr[6:0]}), (2, cfg_fcr), then enter IDLE; cfg_div and cfg_lcr/cfg_fcr SHALL be latched on the cfg_start cycle.
REQ-007 The block SHALL substitute DIV_RESET when the latched divisor is 0.
REQ-008 The block SHALL ignore cfg_start in every other state.
REQ-009 cfg_done SHALL be 1 in IDLE, RD_LSR, RD_RBR and WR_THR, and 0 otherwise.
REQ-010 The poll counter SHALL count in IDLE only and SHALL reset to 0 on leaving IDLE.
REQ-011 IDLE SHALL go to RD_LSR when tx_valid=1, or when the counter reaches POLL_CYCLES-1.
REQ-012 RD_LSR SHALL read addr 5 and capture rdata_i.
- If LSR[0]=1 (DR): next state RD_RBR (receive has priority).
- Else if tx_valid=1 and LSR[5]=1 (THRE): next state WR_THR.
- Else: next state IDLE.
REQ-013 RD_RBR SHALL read addr 0, then pulse rx_valid the next cycle with rx_data=rdata_i and rx_err=captured LSR[4:1], then return to IDLE; there is no backpressure.
REQ-014 WR_THR SHALL write (0, tx_data) with tx_ready=1 in the same cycle, then return to IDLE.
REQ-015 tx_valid dropped before tx_ready SHALL abandon the byte without a write.
REQ-016 With both rx pending and tx_valid, the block SHALL service rx first; tx SHALL be serviced after the next LSR read.
REQ-017 rx_data and rx_err SHALL hold their last values between strobes.

Reset
REQ-018 While rst_n=0, the FSM SHALL be in UNCFG and all outputs, latched config and the poll counter SHALL be 0.
REQ-019 Reset asserted mid-sequence SHALL abort it immediately; no partial strobe SHALL follow deassertion, and reprogramming SHALL require a new cfg_start.

Structure
REQ-020 Package uart_pkg SHALL hold the register address constants (RBR_THR_DLL=0, IER_DLM=1, FCR=2, LCR=3, LSR=5), the LSR bit indices (DR=0, THRE=5) and the state enum.
REQ-021 The poll counter SHALL be the sub-module uart_poll_timer (enable, clear, terminal-count output).

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Config: cfg_div=16'h0108, cfg_lcr=8'h83, cfg_fcr=8'h07, cfg_start -> writes (3,80), (1,01), (0,08), (3,03), (2,07) on 5 consecutive cycles, then cfg_done=1.
- TX: tx_valid with tx_data=8'hA5, LSR=8'h60 -> read 5, then write (0,A5) with tx_ready the next cycle.
- TX blocked: LSR=8'h00 with tx_valid held -> repeated LSR reads, no write; after LSR=8'h20 -> THR write.
- RX: idle, LSR=8'h03 after POLL_CYCLES -> read 5, read 0 returning 8'h3C -> rx_valid, rx_data=3C, rx_err=4'b0001.
- Collision/reset: DR and tx_valid together -> RBR read precedes THR write; rst_n low during W_DLM -> all strobes 0, UNCFG, no writes until cfg_start.
